onchip_memory_dp_pipe: RTL and testbench
========================================

Name: onchip_memory_dp_pipe

Overview:
Parametrised true-dual-port on-chip RAM with two Avalon-MM slaves, s1 and s2, for Nios/HPS shared buffers. Each port is generalised in data width, depth and read latency, and adds an explicit read strobe with a readdatavalid pipeline. It resolves write-write collisions deterministically and flags out-of-range accesses. It sits on the system interconnect in place of the single-port on-chip memory.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
DEPTH, 16384, number of words
ADDR_WIDTH, 14, address bits per port; DEPTH <= 2**ADDR_WIDTH
READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2
INIT_FILE, "onchip_memory_dp_pipe.hex", power-up contents; empty string means all zeros

Ports:
clk  in  1  single clock for both ports
reset  in  1  synchronous, active-high reset
reset_req  in  1  when high, freezes both ports (same effect as clken=0)
clken  in  1  global clock enable
address  in  ADDR_WIDTH  s1 word address
byteenable  in  DATA_WIDTH/8  s1 byte lanes
chipselect  in  1  s1 select
read  in  1  s1 read strobe
write  in  1  s1 write strobe
writedata  in  DATA_WIDTH  s1 write data
readdata  out  DATA_WIDTH  s1 read data
readdatavalid  out  1  s1 read data valid
address2, byteenable2, chipselect2, read2, write2, writedata2, readdata2, readdatavalid2  as for s1, applied to port s2
collision  out  1  sticky flag: an s2 write was dropped
range_err  out  1  sticky flag: an access hit address >= DEPTH

Behaviour:
- en = clken & ~reset_req.
- When en=0: no memory update, all pipeline registers hold, no readdatavalid pulses change state.
- Reset (at a clk edge with reset=1, regardless of en):
  - readdata, readdata2 = 0; readdatavalid, readdatavalid2 = 0.
  - Read pipelines flushed; reads in flight at reset are dropped, with no valid pulse.
  - collision = 0, range_err = 0.
  - Memory contents are NOT cleared.
- A port accepts a write when chipselect & write & en. It accepts a read when chipselect & read & ~write & en. Read and write asserted together: the access is treated as a write only.
- Write: only lanes with byteenable=1 update. byteenable = 0 is a legal no-op.
- Read latency (counted in enabled cycles):
  - READ_LATENCY=1: data and readdatavalid=1 are registered on the edge after acceptance and visible the next cycle.
  - READ_LATENCY=2: an extra output register stage is added.
  - readdatavalid is a one-cycle pulse per accepted read. Back-to-back reads yield back-to-back pulses, full throughput, no waitrequest.
  - readdata holds its last value when not valid.
- Same port, same cycle: a read is not possible alongside a write. For a read of an address written in the previous cycle, the read returns the new data.
- Cross-port write-write to the same address in the same cycle:
  - s1 wins.
  - The s2 write is dropped entirely, for all lanes.
  - collision is set to 1 and stays set until reset.
- Cross-port read of an address the other port writes in the same cycle: returns OLD data (default; see Optional Feature).
- Out of range (address >= DEPTH):
  - Write is ignored.
  - Read still produces a valid pulse with readdata = 0.
  - range_err is set (sticky).
- Reset and an access in the same cycle: reset wins. The access is discarded and memory is not written.

Optional Feature:
Macro ONCHIP_MEM_RDW_BYPASS_EN.
- Defined: on a cross-port read-during-write to the same in-range address, the read returns the NEW data. The merge is per byte lane, using the writer's byteenable; the winning s1 data applies in a collision.
- Undefined: old data is returned. No bypass logic is instantiated.

Test Plan:
1. Reset, then s1 writes 0xDEADBEEF to addr 5 with byteenable=0xF, then reads addr 5 with READ_LATENCY=1 -> readdatavalid pulses 1 cycle after the read; readdata=0xDEADBEEF.
2. s1 writes 0x11223344 to addr 9 with byteenable=0x5, after addr 9 held 0xAABBCCDD; s2 then reads addr 9 -> readdata2=0xAA22CC44.
3. Same cycle: s1 writes 0x1 and s2 writes 0x2, both to addr 3; then read addr 3 -> 0x1; collision=1 and stays 1 until reset.
4. READ_LATENCY=2: reads to addrs 0, 1, 2 on consecutive cycles, with clken=0 for 1 cycle in the middle -> three valid pulses in order; each arrives at 2 enabled cycles plus the stall; data matches.
5. s2 reads addr 7 (holding 0xA) while s1 writes 0xB to addr 7 -> readdata2=0xA without the macro, 0xB with ONCHIP_MEM_RDW_BYPASS_EN.
6. DEPTH=1000: write to addr 1000, then read addr 1000 -> read returns 0 with valid; range_err=1; reset mid-read -> no valid pulse and all flags cleared.

Source files
------------

// File: rtl/onchip_memory_dp_pipe_if.sv
// Avalon-MM slave bundle for one port of onchip_memory_dp_pipe.
// The interconnect side uses the master modport, the memory side uses slave.
interface onchip_memory_dp_pipe_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 14
);
   localparam int unsigned BE_W = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] address;
   logic [BE_W-1:0]       byteenable;
   logic                  chipselect;
   logic                  read;
   logic                  write;
   logic [DATA_WIDTH-1:0] writedata;
   logic [DATA_WIDTH-1:0] readdata;
   logic                  readdatavalid;

   modport master (
      output address, byteenable, chipselect, read, write, writedata,
      input  readdata, readdatavalid
   );

   modport slave (
      input  address, byteenable, chipselect, read, write, writedata,
      output readdata, readdatavalid
   );
endinterface

// File: rtl/onchip_memory_dp_pipe.sv
// True-dual-port on-chip RAM with two Avalon-MM slaves (s1, s2).
// Per-port read strobe with a readdatavalid pipeline of READ_LATENCY (1 or 2)
// enabled cycles, deterministic write-write collision handling (s1 wins,
// the s2 write is dropped and the sticky collision flag is raised) and a
// sticky range_err flag for accesses at address >= DEPTH.
// INIT_FILE names the power-up image handed to the memory-initialisation
// flow of the target library; an empty string means all zeros.
// Optional macro ONCHIP_MEM_RDW_BYPASS_EN: a cross-port read of an address
// written in the same cycle returns the new data (per byte lane); without it
// old data is returned and no bypass logic exists.
module onchip_memory_dp_pipe #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DEPTH        = 16384,
   parameter int unsigned ADDR_WIDTH   = 14,
   parameter int unsigned READ_LATENCY = 1,
   parameter string       INIT_FILE    = "onchip_memory_dp_pipe.hex"
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    reset_req,
   input  logic                    clken,
   onchip_memory_dp_pipe_if.slave  s1,
   onchip_memory_dp_pipe_if.slave  s2,
   output logic                    collision,
   output logic                    range_err
);
   localparam int unsigned BE_W  = DATA_WIDTH / 8;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH+1)'(DEPTH);

   // Port views gathered into arrays so both ports share one description
   logic [ADDR_WIDTH-1:0] addr   [2];
   logic [IDX_W-1:0]      idx    [2];
   logic [BE_W-1:0]       be     [2];
   logic [DATA_WIDTH-1:0] wdata  [2];
   logic [1:0]            cs;
   logic [1:0]            rd;
   logic [1:0]            wr;

   logic                  en;
   logic [1:0]            in_range;
   logic [1:0]            acc_wr;
   logic [1:0]            acc_rd;
   logic [1:0]            mem_we;
   logic                  same_addr;
   logic                  wr_hit;

   logic [DATA_WIDTH-1:0] mem     [DEPTH];
   logic [DATA_WIDTH-1:0] rd_word [2];
   logic [DATA_WIDTH-1:0] st1_data [2];
   logic [1:0]            st1_valid;
   logic [DATA_WIDTH-1:0] out_data [2];
   logic [1:0]            out_valid;

   assign addr[0]  = s1.address;
   assign addr[1]  = s2.address;
   assign be[0]    = s1.byteenable;
   assign be[1]    = s2.byteenable;
   assign wdata[0] = s1.writedata;
   assign wdata[1] = s2.writedata;
   assign cs       = {s2.chipselect, s1.chipselect};
   assign rd       = {s2.read, s1.read};
   assign wr       = {s2.write, s1.write};

   // Access decode: acceptance, range check and write-write collision
   always_comb begin
      en        = clken & ~reset_req;
      same_addr = (addr[0] == addr[1]);
      for (int p = 0; p < 2; p++) begin
         idx[p]      = IDX_W'(addr[p]);
         in_range[p] = ({1'b0, addr[p]} < DEPTH_A);
         acc_wr[p]   = cs[p] & wr[p] & en;
         acc_rd[p]   = cs[p] & rd[p] & ~wr[p] & en;
      end
      wr_hit    = acc_wr[0] & acc_wr[1] & same_addr & in_range[0];
      mem_we[0] = acc_wr[0] & in_range[0] & ~reset;
      mem_we[1] = acc_wr[1] & in_range[1] & ~wr_hit & ~reset;
   end

   // Memory array: byte-lane writes from both ports, no reset on contents
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (mem_we[p]) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
               if (be[p][b]) begin
                  mem[idx[p]][8*b +: 8] <= wdata[p][8*b +: 8];
               end
            end
         end
      end
   end

   // Read word selection: zero when out of range, optional cross-port bypass
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_word[p] = in_range[p] ? mem[idx[p]] : '0;
`ifdef ONCHIP_MEM_RDW_BYPASS_EN
         if (in_range[p] && mem_we[1-p] && same_addr) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
               if (be[1-p][b]) begin
                  rd_word[p][8*b +: 8] = wdata[1-p][8*b +: 8];
               end
            end
         end
`endif
      end
   end

   // First read stage: capture data on accepted reads, valid pulses once
   always_ff @(posedge clk) begin
      if (reset) begin
         st1_valid   <= '0;
         st1_data[0] <= '0;
         st1_data[1] <= '0;
      end else if (en) begin
         for (int p = 0; p < 2; p++) begin
            st1_valid[p] <= acc_rd[p];
            if (acc_rd[p]) begin
               st1_data[p] <= rd_word[p];
            end
         end
      end
   end

   // Sticky status flags, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         collision <= 1'b0;
         range_err <= 1'b0;
      end else begin
         if (wr_hit) begin
            collision <= 1'b1;
         end
         if ((((acc_wr[0] | acc_rd[0]) & ~in_range[0]) |
              ((acc_wr[1] | acc_rd[1]) & ~in_range[1])) != 1'b0) begin
            range_err <= 1'b1;
         end
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] st2_data [2];
      logic [1:0]            st2_valid;

      // Extra output register stage; data only moves with a valid word
      always_ff @(posedge clk) begin
         if (reset) begin
            st2_valid   <= '0;
            st2_data[0] <= '0;
            st2_data[1] <= '0;
         end else if (en) begin
            st2_valid <= st1_valid;
            for (int p = 0; p < 2; p++) begin
               if (st1_valid[p]) begin
                  st2_data[p] <= st1_data[p];
               end
            end
         end
      end

      assign out_data[0] = st2_data[0];
      assign out_data[1] = st2_data[1];
      assign out_valid   = st2_valid;
   end else begin : g_lat1
      assign out_data[0] = st1_data[0];
      assign out_data[1] = st1_data[1];
      assign out_valid   = st1_valid;
   end

   assign s1.readdata      = out_data[0];
   assign s2.readdata      = out_data[1];
   assign s1.readdatavalid = out_valid[0];
   assign s2.readdatavalid = out_valid[1];

endmodule

// File: tb/tb_onchip_memory_dp_pipe.sv
// Scoreboard bench for onchip_memory_dp_pipe: two instances (READ_LATENCY 1
// and 2, DEPTH 1000) receive identical stimulus; expected read words and
// their due enabled-edge count are queued at issue and popped by a monitor.
`timescale 1ns/1ps
module tb_onchip_memory_dp_pipe;
   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 10;
   localparam int unsigned DEPTH = 1000;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic reset_req = 1'b0;
   logic clken = 1'b1;

   always #5 clk = ~clk;

   logic [AW-1:0] t_addr [2];
   logic [3:0]    t_be   [2];
   logic          t_cs   [2];
   logic          t_rd   [2];
   logic          t_wr   [2];
   logic [DW-1:0] t_wd   [2];

   onchip_memory_dp_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a1 ();
   onchip_memory_dp_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a2 ();
   onchip_memory_dp_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();
   onchip_memory_dp_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b2 ();

   assign a1.address = t_addr[0]; assign b1.address = t_addr[0];
   assign a2.address = t_addr[1]; assign b2.address = t_addr[1];
   assign a1.byteenable = t_be[0]; assign b1.byteenable = t_be[0];
   assign a2.byteenable = t_be[1]; assign b2.byteenable = t_be[1];
   assign a1.chipselect = t_cs[0]; assign b1.chipselect = t_cs[0];
   assign a2.chipselect = t_cs[1]; assign b2.chipselect = t_cs[1];
   assign a1.read = t_rd[0]; assign b1.read = t_rd[0];
   assign a2.read = t_rd[1]; assign b2.read = t_rd[1];
   assign a1.write = t_wr[0]; assign b1.write = t_wr[0];
   assign a2.write = t_wr[1]; assign b2.write = t_wr[1];
   assign a1.writedata = t_wd[0]; assign b1.writedata = t_wd[0];
   assign a2.writedata = t_wd[1]; assign b2.writedata = t_wd[1];

   logic col_a, rng_a, col_b, rng_b;

   onchip_memory_dp_pipe #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
      .READ_LATENCY(1), .INIT_FILE("")
   ) dut_l1 (
      .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
      .s1(a1), .s2(a2), .collision(col_a), .range_err(rng_a)
   );

   onchip_memory_dp_pipe #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
      .READ_LATENCY(2), .INIT_FILE("")
   ) dut_l2 (
      .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
      .s1(b1), .s2(b2), .collision(col_b), .range_err(rng_b)
   );

   logic          mv [4];
   logic [DW-1:0] md [4];
   assign mv[0] = a1.readdatavalid; assign md[0] = a1.readdata;
   assign mv[1] = a2.readdatavalid; assign md[1] = a2.readdata;
   assign mv[2] = b1.readdatavalid; assign md[2] = b1.readdata;
   assign mv[3] = b2.readdatavalid; assign md[3] = b2.readdata;

   exp_t q [4][$];
   int   en_edges = 0;
   int   checks = 0;
   int   errors = 0;
   int   flag_req = 0;
   int   flag_done = 0;
   logic exp_col, exp_rng, exp_zero;
   logic fin_req = 1'b0;
   logic fin_done = 1'b0;

   // Count enabled edges; read latency is measured in these
   always @(posedge clk) begin
      if (!reset && clken && !reset_req) en_edges <= en_edges + 1;
   end

   // Monitor: pops the scoreboard on each consumed valid, checks flags on request
   always @(negedge clk) begin
      exp_t e;
      if (!reset && clken && !reset_req) begin
         for (int k = 0; k < 4; k++) begin
            if (mv[k]) begin
               checks++;
               if (q[k].size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_valid ch%0d: data %h, nothing queued", k, md[k]);
               end else begin
                  e = q[k].pop_front();
                  if (md[k] !== e.data || en_edges != e.due) begin
                     errors++;
                     $display("FAIL read_ch%0d: got %h at edge %0d, want %h at edge %0d",
                              k, md[k], en_edges, e.data, e.due);
                  end
               end
            end
         end
      end
      if (flag_req != flag_done) begin
         flag_done = flag_req;
         checks += 2;
         if (col_a !== exp_col || col_b !== exp_col) begin
            errors++;
            $display("FAIL collision: got %b/%b, want %b", col_a, col_b, exp_col);
         end
         if (rng_a !== exp_rng || rng_b !== exp_rng) begin
            errors++;
            $display("FAIL range_err: got %b/%b, want %b", rng_a, rng_b, exp_rng);
         end
         if (exp_zero) begin
            for (int k = 0; k < 4; k++) begin
               checks++;
               if (md[k] !== '0 || mv[k] !== 1'b0) begin
                  errors++;
                  $display("FAIL reset_out_ch%0d: got data %h valid %b, want 0 0", k, md[k], mv[k]);
               end
            end
         end
      end
      if (fin_req && !fin_done) begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (q[k].size() != 0) begin
               errors++;
               $display("FAIL drained_ch%0d: %0d reads outstanding, want 0", k, q[k].size());
            end
         end
         fin_done = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clr();
      for (int p = 0; p < 2; p++) begin
         t_addr[p] = '0; t_be[p] = '0; t_cs[p] = 1'b0;
         t_rd[p] = 1'b0; t_wr[p] = 1'b0; t_wd[p] = '0;
      end
   endtask

   task automatic wr_p(input int p, input logic [AW-1:0] a, input logic [3:0] b,
                       input logic [DW-1:0] d);
      t_addr[p] = a; t_be[p] = b; t_cs[p] = 1'b1;
      t_rd[p] = 1'b0; t_wr[p] = 1'b1; t_wd[p] = d;
   endtask

   // Issue a read and, when push is set, queue its expected word for both DUTs
   task automatic rd_p(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit push);
      exp_t e;
      t_addr[p] = a; t_be[p] = 4'hF; t_cs[p] = 1'b1;
      t_rd[p] = 1'b1; t_wr[p] = 1'b0;
      if (push) begin
         e.data = d; e.due = en_edges + 1; q[p].push_back(e);
         e.due = en_edges + 2; q[2 + p].push_back(e);
      end
   endtask

   task automatic chk_flags(input logic c, input logic r, input logic z);
      exp_col = c; exp_rng = r; exp_zero = z;
      flag_req++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] rdw_exp;
`ifdef ONCHIP_MEM_RDW_BYPASS_EN
      rdw_exp = 32'h0000_000B;
`else
      rdw_exp = 32'h0000_000A;
`endif
      clr();
      reset = 1'b1;
      tick(); tick();
      chk_flags(1'b0, 1'b0, 1'b1);
      tick();
      reset = 1'b0;

      // Full-word write then read back
      wr_p(0, 10'd5, 4'hF, 32'hDEAD_BEEF); tick();
      clr(); rd_p(0, 10'd5, 32'hDEAD_BEEF, 1'b1); tick();
      clr(); tick();

      // Partial byte-enable write; cross-port and same-port read-after-write
      wr_p(0, 10'd9, 4'hF, 32'hAABB_CCDD); tick();
      wr_p(0, 10'd9, 4'h5, 32'h1122_3344); tick();
      clr(); rd_p(1, 10'd9, 32'hAA22_CC44, 1'b1); rd_p(0, 10'd9, 32'hAA22_CC44, 1'b1); tick();
      clr(); wr_p(1, 10'd9, 4'h0, 32'hFFFF_FFFF); tick();
      clr(); rd_p(0, 10'd9, 32'hAA22_CC44, 1'b1); tick();
      clr(); tick();

      // Write-write collision: s1 wins, flag sticks
      wr_p(0, 10'd3, 4'hF, 32'h1); wr_p(1, 10'd3, 4'hF, 32'h2); tick();
      clr(); chk_flags(1'b1, 1'b0, 1'b0);
      rd_p(0, 10'd3, 32'h1, 1'b1); rd_p(1, 10'd3, 32'h1, 1'b1); tick();
      clr(); tick();

      // Back-to-back reads with a one-cycle clken stall
      wr_p(0, 10'd0, 4'hF, 32'h100); wr_p(1, 10'd1, 4'hF, 32'h101); tick();
      clr(); wr_p(0, 10'd2, 4'hF, 32'h102); tick();
      clr(); rd_p(0, 10'd0, 32'h100, 1'b1); tick();
      rd_p(0, 10'd1, 32'h101, 1'b1); tick();
      clken = 1'b0; rd_p(0, 10'd2, 32'h0, 1'b0); tick();
      clken = 1'b1; rd_p(0, 10'd2, 32'h102, 1'b1); tick();
      clr(); tick(); tick(); tick();

      // reset_req freezes the memory: the second write is lost
      wr_p(0, 10'd4, 4'hF, 32'h44); tick();
      reset_req = 1'b1; wr_p(0, 10'd4, 4'hF, 32'h55); tick();
      reset_req = 1'b0; clr(); rd_p(1, 10'd4, 32'h44, 1'b1); tick();
      clr(); tick(); tick();

      // Cross-port read during write
      wr_p(0, 10'd7, 4'hF, 32'hA); tick();
      wr_p(0, 10'd7, 4'hF, 32'hB); rd_p(1, 10'd7, rdw_exp, 1'b1); tick();
      clr(); rd_p(1, 10'd7, 32'hB, 1'b1); tick();
      clr(); tick(); tick();

      // Out-of-range write and reads
      wr_p(0, 10'd1000, 4'hF, 32'h77); tick();
      clr(); chk_flags(1'b1, 1'b1, 1'b0);
      rd_p(0, 10'd1000, 32'h0, 1'b1); rd_p(1, 10'd1023, 32'h0, 1'b1); tick();
      clr(); tick(); tick(); tick();

      // Reset with a read and a write in the same cycle: both discarded
      reset = 1'b1; rd_p(0, 10'd9, 32'h0, 1'b0); wr_p(1, 10'd5, 4'hF, 32'h1234_5678); tick();
      reset = 1'b0; clr(); chk_flags(1'b0, 1'b0, 1'b1); tick();
      rd_p(0, 10'd5, 32'hDEAD_BEEF, 1'b1); tick();
      clr(); tick(); tick(); tick();

      fin_req = 1'b1;
      repeat (4) @(negedge clk);
      if (!fin_done) begin
         $display("FAIL final_check: monitor did not complete");
         $fatal(1, "final check not reached");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
